// File: rtl/cpu_bus_router.sv
// cpu_bus_router: address-decoded router from a single-outstanding CPU bus to
// NUM_REGIONS memory ports. It merges partial-strobe writes with a
// read-modify-write, times out slow ports, and flags unmapped addresses.
module cpu_bus_router #(
  parameter int unsigned NUM_REGIONS    = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE  = {32'h0000_0A94, 32'h0000_0000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_LIMIT = {32'h7FFF_FFFF, 32'h0000_0A90},
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_WIDTH-1:0]             rw_address,
  input  logic                              read_request,
  input  logic                              write_request,
  input  logic [DATA_WIDTH-1:0]             write_data,
  input  logic [STRB_WIDTH-1:0]             write_strobe,
  output logic [DATA_WIDTH-1:0]             read_data,
  output logic                              read_response,
  output logic                              write_response,
  output logic                              bus_error,
  output logic                              protocol_error,
  output logic [ADDR_WIDTH-1:0]             mem_address,
  output logic [DATA_WIDTH-1:0]             mem_write_data,
  output logic [NUM_REGIONS-1:0]            mem_read,
  output logic [NUM_REGIONS-1:0]            mem_write,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] mem_read_data,
  input  logic [NUM_REGIONS-1:0]            mem_ready
);

  localparam int unsigned REGION_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

  state_t                  state, state_nxt;
  logic [REGION_W-1:0]     region, region_nxt;
  logic                    is_write, is_write_nxt;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_nxt;
  logic [STRB_WIDTH-1:0]   strb_q, strb_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt, cnt_inc;
  logic                    timeout_hit;

  logic [DATA_WIDTH-1:0]   read_data_nxt, mem_write_data_nxt, merged;
  logic [ADDR_WIDTH-1:0]   mem_address_nxt;
  logic [NUM_REGIONS-1:0]  mem_read_nxt, mem_write_nxt, region_onehot;
  logic                    read_response_nxt, write_response_nxt, bus_error_nxt, protocol_error_nxt;

  logic                    hit;
  logic [REGION_W-1:0]     hit_idx;
  logic                    sel_ready;
  logic [DATA_WIDTH-1:0]   sel_data;

  // Address decode: scan downward so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((rw_address >= REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (rw_address <= REGION_LIMIT[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit     = 1'b1;
        hit_idx = REGION_W'(i);
      end
    end
  end

  // Select ready and read data of the latched region; other ports are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (region == REGION_W'(i)) begin
        sel_ready = mem_ready[i];
        sel_data  = mem_read_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Byte-lane merge of latched write data over the word read back.
  always_comb begin
    merged = '0;
    for (int k = 0; k < STRB_WIDTH; k++) begin
      merged[k*8 +: 8] = strb_q[k] ? wdata_q[k*8 +: 8] : sel_data[k*8 +: 8];
    end
  end

  // Saturating wait counter; the timeout fires on the cycle it reaches the limit.
  always_comb begin
    cnt_inc     = (cnt == CNT_W'(TIMEOUT_CYCLES)) ? cnt : cnt + CNT_W'(1);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt          = state;
    region_nxt         = region;
    is_write_nxt       = is_write;
    wdata_nxt          = wdata_q;
    strb_nxt           = strb_q;
    read_data_nxt      = read_data;
    mem_address_nxt    = mem_address;
    mem_write_data_nxt = mem_write_data;
    protocol_error_nxt = protocol_error;
    bus_error_nxt      = 1'b0;
    read_response_nxt  = 1'b0;
    write_response_nxt = 1'b0;
    mem_read_nxt       = '0;
    mem_write_nxt      = '0;
    region_onehot      = '0;

    case (state)
      IDLE: begin
        if (read_request || write_request) begin
          mem_address_nxt = rw_address;
          is_write_nxt    = write_request;
          wdata_nxt       = write_data;
          strb_nxt        = write_strobe;
          region_nxt      = hit_idx;
          if (read_request && write_request) protocol_error_nxt = 1'b1;
          if (!hit) begin
            state_nxt     = RESP;
            bus_error_nxt = 1'b1;
            if (!write_request) read_data_nxt = '0;
          end else if (!write_request) begin
            state_nxt = RD;
          end else if (&write_strobe) begin
            state_nxt          = WR;
            mem_write_data_nxt = write_data;
          end else if (write_strobe == '0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = RMW_RD;
          end
        end
      end
      RD: begin
        if (sel_ready) begin
          read_data_nxt = sel_data;
          state_nxt     = RESP;
        end else if (timeout_hit) begin
          read_data_nxt = '0;
          bus_error_nxt = 1'b1;
          state_nxt     = RESP;
        end
      end
      RMW_RD: begin
        if (sel_ready) begin
          mem_write_data_nxt = merged;
          state_nxt          = RMW_WR;
        end else if (timeout_hit) begin
          bus_error_nxt = 1'b1;
          state_nxt     = RESP;
        end
      end
      WR, RMW_WR: begin
        if (sel_ready) begin
          state_nxt = RESP;
        end else if (timeout_hit) begin
          bus_error_nxt = 1'b1;
          state_nxt     = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == RESP) begin
      read_response_nxt  = !is_write_nxt;
      write_response_nxt = is_write_nxt;
    end

    for (int i = 0; i < NUM_REGIONS; i++) region_onehot[i] = (region_nxt == REGION_W'(i));
    if (state_nxt == RD || state_nxt == RMW_RD) mem_read_nxt  = region_onehot;
    if (state_nxt == WR || state_nxt == RMW_WR) mem_write_nxt = region_onehot;

    cnt_nxt = (state_nxt != state) ? '0 : cnt_inc;
  end

  // State, latches and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      region         <= '0;
      is_write       <= 1'b0;
      wdata_q        <= '0;
      strb_q         <= '0;
      cnt            <= '0;
      read_data      <= '0;
      read_response  <= 1'b0;
      write_response <= 1'b0;
      bus_error      <= 1'b0;
      protocol_error <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read       <= '0;
      mem_write      <= '0;
    end else begin
      state          <= state_nxt;
      region         <= region_nxt;
      is_write       <= is_write_nxt;
      wdata_q        <= wdata_nxt;
      strb_q         <= strb_nxt;
      cnt            <= cnt_nxt;
      read_data      <= read_data_nxt;
      read_response  <= read_response_nxt;
      write_response <= write_response_nxt;
      bus_error      <= bus_error_nxt;
      protocol_error <= protocol_error_nxt;
      mem_address    <= mem_address_nxt;
      mem_write_data <= mem_write_data_nxt;
      mem_read       <= mem_read_nxt;
      mem_write      <= mem_write_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_bus_router.sv
// Testbench for cpu_bus_router: directed scenarios plus a short random run,
// expected responses queued at stimulus time and checked on completion.
module tb_cpu_bus_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rw_address;
  logic        read_request, write_request;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic [31:0] read_data;
  logic        read_response, write_response, bus_error, protocol_error;
  logic [31:0] mem_address, mem_write_data;
  logic [1:0]  mem_read, mem_write;
  logic [63:0] mem_read_data;
  logic [1:0]  mem_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        be;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int          obs_lat, obs_rd0, obs_rd1, obs_wr0, obs_wr1;
  logic [31:0] obs_wword, obs_rdata, obs_addr;
  logic        obs_be, obs_rresp, obs_wresp, obs_tail;

  always #5 clk = ~clk;

  cpu_bus_router #(
    .NUM_REGIONS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .REGION_BASE({32'h0000_0A94, 32'h0000_0000}),
    .REGION_LIMIT({32'h7FFF_FFFF, 32'h0000_0A90}),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .rw_address(rw_address), .read_request(read_request),
    .write_request(write_request), .write_data(write_data), .write_strobe(write_strobe),
    .read_data(read_data), .read_response(read_response), .write_response(write_response),
    .bus_error(bus_error), .protocol_error(protocol_error), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready)
  );

  // Issue one request and act as the memory; records observations only.
  // w1/w2 = wait cycles of the read/write phase; respond=0 never raises ready.
  // While waiting, the non-selected port's ready is raised as noise.
  task automatic run_txn(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [31:0] wd, input logic [3:0] st,
                         input int w1, input int w2, input logic [31:0] word,
                         input logic respond);
    int rc = 0;
    int wc = 0;
    obs_lat = -1; obs_rd0 = 0; obs_rd1 = 0; obs_wr0 = 0; obs_wr1 = 0;
    obs_wword = '0; obs_rdata = '0; obs_addr = '0;
    obs_be = 1'b0; obs_rresp = 1'b0; obs_wresp = 1'b0;
    @(negedge clk);
    rw_address = addr; read_request = rd; write_request = wr;
    write_data = wd; write_strobe = st;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      read_request = 1'b0; write_request = 1'b0;
      mem_ready = 2'b00;
      mem_read_data = {32'hBAD1_BAD1, 32'hBAD0_BAD0};
      if (read_response || write_response) begin
        obs_lat = cyc; obs_rdata = read_data; obs_be = bus_error;
        obs_rresp = read_response; obs_wresp = write_response; obs_addr = mem_address;
        break;
      end
      if (mem_read[0])  obs_rd0++;
      if (mem_read[1])  obs_rd1++;
      if (mem_write[0]) obs_wr0++;
      if (mem_write[1]) obs_wr1++;
      if (|mem_read) begin
        rc++;
        if (respond && rc == w1 + 1) begin
          mem_ready = mem_read;
          if (mem_read[0]) mem_read_data[31:0] = word;
          else             mem_read_data[63:32] = word;
        end else begin
          mem_ready = ~mem_read;
        end
      end
      if (|mem_write) begin
        wc++;
        obs_wword = mem_write_data;
        if (respond && wc == w2 + 1) mem_ready = mem_write;
        else                         mem_ready = ~mem_write;
      end
    end
    mem_ready = 2'b00;
    @(negedge clk);
    obs_tail = read_response | write_response | bus_error | (|mem_read) | (|mem_write);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data got %h want 0", read_data); end
    checks++; if ({read_response, write_response, bus_error, protocol_error} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {read_response, write_response, bus_error, protocol_error}); end
    checks++; if ({mem_read, mem_write} !== 4'b0 || mem_address !== 32'h0 || mem_write_data !== 32'h0) begin errors++; $display("FAIL reset_mem got rd=%b wr=%b a=%h d=%h want all 0", mem_read, mem_write, mem_address, mem_write_data); end
    rst = 1'b0;
  endtask

  task automatic test_read();
    exp_t e;
    sb.push_back('{wr: 1'b0, data: 32'hDEADBEEF, be: 1'b0, lat: 5});
    run_txn(32'h100, 1'b1, 1'b0, 32'h0, 4'h0, 3, 0, 32'hDEADBEEF, 1'b1);
    e = sb.pop_front();
    checks++; if (obs_lat !== e.lat) begin errors++; $display("FAIL read_latency got %0d want %0d", obs_lat, e.lat); end
    checks++; if (obs_rdata !== e.data || obs_rresp !== 1'b1 || obs_be !== e.be) begin errors++; $display("FAIL read_data got %h rr=%b be=%b want %h rr=1 be=0", obs_rdata, obs_rresp, obs_be, e.data); end
    checks++; if (obs_rd0 !== 4 || obs_rd1 !== 0) begin errors++; $display("FAIL read_strobe got rd0=%0d rd1=%0d want 4/0", obs_rd0, obs_rd1); end
    checks++; if (obs_addr !== 32'h100) begin errors++; $display("FAIL read_address got %h want 00000100", obs_addr); end
    checks++; if (obs_tail !== 1'b0) begin errors++; $display("FAIL read_pulse got tail=%b want 0", obs_tail); end
  endtask

  task automatic test_rmw();
    exp_t e;
    sb.push_back('{wr: 1'b1, data: 32'h112233AB, be: 1'b0, lat: 6});
    run_txn(32'h2000, 1'b0, 1'b1, 32'h0000_00AB, 4'b0001, 1, 2, 32'h11223344, 1'b1);
    e = sb.pop_front();
    checks++; if (obs_wword !== e.data) begin errors++; $display("FAIL rmw_byte_word got %h want %h", obs_wword, e.data); end
    checks++; if (obs_lat !== e.lat || obs_wresp !== 1'b1 || obs_be !== e.be) begin errors++; $display("FAIL rmw_byte_resp got lat=%0d wr=%b be=%b want lat=%0d wr=1 be=0", obs_lat, obs_wresp, obs_be, e.lat); end
    checks++; if (obs_rd1 !== 2 || obs_wr1 !== 3 || obs_rd0 !== 0 || obs_wr0 !== 0) begin errors++; $display("FAIL rmw_byte_strobes got rd1=%0d wr1=%0d rd0=%0d wr0=%0d want 2/3/0/0", obs_rd1, obs_wr1, obs_rd0, obs_wr0); end
    sb.push_back('{wr: 1'b1, data: 32'hCAFE3344, be: 1'b0, lat: 3});
    run_txn(32'h2000, 1'b0, 1'b1, 32'hCAFE_0000, 4'b1100, 0, 0, 32'h11223344, 1'b1);
    e = sb.pop_front();
    checks++; if (obs_wword !== e.data || obs_lat !== e.lat) begin errors++; $display("FAIL rmw_half got %h lat=%0d want %h lat=%0d", obs_wword, obs_lat, e.data, e.lat); end
  endtask

  task automatic test_strobe_zero();
    run_txn(32'h2000, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0000, 0, 0, 32'h0, 1'b1);
    checks++; if (obs_lat !== 1 || obs_wresp !== 1'b1 || obs_be !== 1'b0) begin errors++; $display("FAIL strb0_resp got lat=%0d wr=%b be=%b want 1/1/0", obs_lat, obs_wresp, obs_be); end
    checks++; if (obs_rd0 + obs_rd1 + obs_wr0 + obs_wr1 !== 0) begin errors++; $display("FAIL strb0_access got %0d strobe cycles want 0", obs_rd0 + obs_rd1 + obs_wr0 + obs_wr1); end
    checks++; if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data_hold got %h want deadbeef", obs_rdata); end
  endtask

  task automatic test_full_write();
    run_txn(32'h10, 1'b0, 1'b1, 32'h5A5A_1234, 4'b1111, 0, 1, 32'h0, 1'b1);
    checks++; if (obs_wword !== 32'h5A5A_1234 || obs_wr0 !== 2 || obs_rd0 !== 0) begin errors++; $display("FAIL full_write got %h wr0=%0d rd0=%0d want 5a5a1234/2/0", obs_wword, obs_wr0, obs_rd0); end
    checks++; if (obs_lat !== 3 || obs_wresp !== 1'b1) begin errors++; $display("FAIL full_write_lat got %0d wr=%b want 3/1", obs_lat, obs_wresp); end
  endtask

  task automatic test_decode();
    run_txn(32'h8000_0000, 1'b1, 1'b0, 32'h0, 4'h0, 0, 0, 32'h77777777, 1'b1);
    checks++; if (obs_lat !== 1 || obs_rresp !== 1'b1 || obs_be !== 1'b1 || obs_rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read got lat=%0d rr=%b be=%b d=%h want 1/1/1/0", obs_lat, obs_rresp, obs_be, obs_rdata); end
    checks++; if (obs_rd0 + obs_rd1 !== 0) begin errors++; $display("FAIL unmapped_access got %0d want 0", obs_rd0 + obs_rd1); end
    run_txn(32'h0000_0A91, 1'b1, 1'b0, 32'h0, 4'h0, 0, 0, 32'h77777777, 1'b1);
    checks++; if (obs_lat !== 1 || obs_be !== 1'b1) begin errors++; $display("FAIL gap_0a91 got lat=%0d be=%b want 1/1", obs_lat, obs_be); end
    run_txn(32'h0000_0A90, 1'b1, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0000_0A90, 1'b1);
    checks++; if (obs_rd0 !== 1 || obs_rdata !== 32'h0000_0A90 || obs_be !== 1'b0) begin errors++; $display("FAIL limit0 got rd0=%0d d=%h be=%b want 1/00000a90/0", obs_rd0, obs_rdata, obs_be); end
    run_txn(32'h0000_0A94, 1'b1, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0000_0A94, 1'b1);
    checks++; if (obs_rd1 !== 1 || obs_rdata !== 32'h0000_0A94) begin errors++; $display("FAIL base1 got rd1=%0d d=%h want 1/00000a94", obs_rd1, obs_rdata); end
    run_txn(32'h7FFF_FFFF, 1'b1, 1'b0, 32'h0, 4'h0, 1, 0, 32'h1357_9BDF, 1'b1);
    checks++; if (obs_rd1 !== 2 || obs_rdata !== 32'h1357_9BDF || obs_lat !== 3) begin errors++; $display("FAIL limit1 got rd1=%0d d=%h lat=%0d want 2/13579bdf/3", obs_rd1, obs_rdata, obs_lat); end
    run_txn(32'h8000_0000, 1'b0, 1'b1, 32'h1, 4'b1111, 0, 0, 32'h0, 1'b1);
    checks++; if (obs_wresp !== 1'b1 || obs_be !== 1'b1 || obs_wr0 + obs_wr1 !== 0 || obs_rdata !== 32'h1357_9BDF) begin errors++; $display("FAIL unmapped_write got wr=%b be=%b acc=%0d d=%h want 1/1/0/13579bdf", obs_wresp, obs_be, obs_wr0 + obs_wr1, obs_rdata); end
  endtask

  task automatic test_timeout();
    exp_t e;
    sb.push_back('{wr: 1'b0, data: 32'h0, be: 1'b1, lat: 5});
    run_txn(32'h100, 1'b1, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0);
    e = sb.pop_front();
    checks++; if (obs_rd0 !== 4 || obs_lat !== e.lat) begin errors++; $display("FAIL timeout_read got rd0=%0d lat=%0d want 4/%0d", obs_rd0, obs_lat, e.lat); end
    checks++; if (obs_rresp !== 1'b1 || obs_be !== e.be || obs_rdata !== e.data) begin errors++; $display("FAIL timeout_read_resp got rr=%b be=%b d=%h want 1/1/0", obs_rresp, obs_be, obs_rdata); end
    run_txn(32'h2000, 1'b0, 1'b1, 32'h1, 4'b1111, 0, 0, 32'h0, 1'b0);
    checks++; if (obs_wr1 !== 4 || obs_wresp !== 1'b1 || obs_be !== 1'b1) begin errors++; $display("FAIL timeout_write got wr1=%0d wr=%b be=%b want 4/1/1", obs_wr1, obs_wresp, obs_be); end
  endtask

  task automatic test_protocol();
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL proto_initial got %b want 0", protocol_error); end
    run_txn(32'h2000, 1'b1, 1'b1, 32'h2468_ACE0, 4'b1111, 0, 0, 32'h0, 1'b1);
    checks++; if (obs_wresp !== 1'b1 || obs_rresp !== 1'b0 || obs_wr1 !== 1 || obs_rd1 !== 0 || obs_wword !== 32'h2468_ACE0) begin errors++; $display("FAIL proto_write got wr=%b rr=%b wr1=%0d rd1=%0d d=%h want 1/0/1/0/2468ace0", obs_wresp, obs_rresp, obs_wr1, obs_rd1, obs_wword); end
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL proto_set got %b want 1", protocol_error); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] addr, word;
    int w;
    for (int i = 0; i < 8; i++) begin
      addr = (i % 4 < 2) ? 32'($urandom_range(0, 32'h0A90)) : 32'($urandom_range(32'h0A94, 32'h7FFF_FFFF));
      word = $urandom;
      w = int'($urandom_range(0, 3));
      sb.push_back('{wr: (i % 2 == 1), data: word, be: 1'b0, lat: w + 2});
      if (i % 2 == 1) run_txn(addr, 1'b0, 1'b1, word, 4'b1111, 0, w, 32'h0, 1'b1);
      else            run_txn(addr, 1'b1, 1'b0, 32'h0, 4'h0, w, 0, word, 1'b1);
      if (sb.size() == 0) begin
        checks++; errors++; $display("FAIL b2b_queue empty at %0d", i);
      end else begin
        e = sb.pop_front();
        checks++; if (obs_lat !== e.lat || obs_be !== e.be || obs_wresp !== e.wr || obs_rresp !== !e.wr) begin errors++; $display("FAIL b2b_resp[%0d] got lat=%0d be=%b wr=%b rr=%b want lat=%0d be=0 wr=%b", i, obs_lat, obs_be, obs_wresp, obs_rresp, e.lat, e.wr); end
        checks++; if ((e.wr ? obs_wword : obs_rdata) !== e.data) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, e.wr ? obs_wword : obs_rdata, e.data); end
      end
    end
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b want 1", protocol_error); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    rw_address = 32'h100; read_request = 1'b1;
    @(negedge clk);
    read_request = 1'b0;
    @(negedge clk);
    checks++; if (mem_read !== 2'b01) begin errors++; $display("FAIL midrst_pre got %b want 01", mem_read); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({mem_read, mem_write, read_response, write_response, bus_error, protocol_error} !== 8'b0 || read_data !== 32'h0 || mem_address !== 32'h0) begin errors++; $display("FAIL midrst_clear got rd=%b wr=%b pe=%b a=%h want all 0", mem_read, mem_write, protocol_error, mem_address); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (read_response || write_response || (|mem_read)) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_noresp got activity=%b want 0", seen); end
  endtask

  initial begin
    rst = 1'b1;
    rw_address = '0; read_request = 1'b0; write_request = 1'b0;
    write_data = '0; write_strobe = '0;
    mem_read_data = '0; mem_ready = '0;
    test_reset();
    test_read();
    test_rmw();
    test_strobe_zero();
    test_full_write();
    test_decode();
    test_timeout();
    test_protocol();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
